// File: rtl/decode_stage.sv
// decode_stage: registered instruction decoder with valid/ready handshake.
// Define DECODE_SCOREBOARD_EN to track outstanding LOADs and stall dependent instructions.
module decode_stage #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4,
  parameter int MAX_LD   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [15:0]         instr,
  input  logic [4:0]          flags,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [7:0]          opcode,
  output logic [REG_AW-1:0]   rdest,
  output logic [REG_AW-1:0]   src_a,
  output logic [REG_AW-1:0]   src_b,
  output logic                use_a,
  output logic                use_b,
  output logic [DATA_W-1:0]   imm,
  output logic [1:0]          instr_type,
  output logic                wb,
  output logic                illegal,
  input  logic                ld_done,
  input  logic [REG_AW-1:0]   ld_reg,
  output logic [NUM_REGS-1:0] ld_busy
);
  logic [3:0] hi, ext, cond;
  logic z, c, f, l, n;
  logic take, hazard, accept, is_load;
  logic d_ua, d_ub, d_wb, d_ill;
  logic [1:0] d_type;
  logic [DATA_W-1:0] d_imm;
  assign hi = instr[15:12];
  assign ext = instr[7:4];
  assign cond = instr[11:8];
  assign {z, c, f, l, n} = flags;
  assign is_load = hi == 4'h4 && ext == 4'h0;
  assign accept = instr_valid & instr_ready;
  assign instr_ready = (!dec_valid | dec_ready) & !hazard;
  always_comb begin
    case (cond)
      4'h0: take = z;
      4'h1: take = !z;
      4'h2: take = c;
      4'h3: take = !c;
      4'h4: take = l;
      4'h5: take = !l;
      4'h6: take = n;
      4'h7: take = !n;
      4'h8: take = f;
      4'h9: take = !f;
      4'hA: take = !l | !z;
      4'hB: take = l | z;
      4'hC: take = !n & !z;
      4'hD: take = n | z;
      4'hE: take = 1'b1;
      default: take = 1'b0;
    endcase
  end
  always_comb begin
    d_type = 2'b00;
    d_ua = 1'b0;
    d_ub = 1'b0;
    d_wb = 1'b0;
    d_ill = 1'b0;
    d_imm = '0;
    case (hi)
      4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC: begin
        d_type = 2'b01;
        d_ua = 1'b1;
        d_wb = hi != 4'hB && hi != 4'hC;
        d_imm = {{(DATA_W-8){instr[7]}}, instr[7:0]};
      end
      4'h8:
        if (!ext[2]) begin
          d_type = 2'b01;
          d_ua = 1'b1;
          d_wb = 1'b1;
          d_imm = {{(DATA_W-4){1'b0}}, instr[3:0]};
        end else if (!ext[3]) begin
          d_ua = 1'b1;
          d_ub = 1'b1;
          d_wb = 1'b1;
        end else d_ill = 1'b1;
      4'h0:
        if (ext inside {4'hA, 4'hC, 4'hD, 4'hE}) d_ill = 1'b1;
        else if (ext != 4'h0) begin
          d_ua = 1'b1;
          d_ub = 1'b1;
          d_wb = ext != 4'h8 && ext != 4'hB;
        end
      4'h4:
        case (ext)
          4'h0: begin
            d_type = 2'b10;
            d_ub = 1'b1;
            d_wb = 1'b1;
          end
          4'h4: begin
            d_type = 2'b10;
            d_ua = 1'b1;
            d_ub = 1'b1;
          end
          4'h8: begin
            d_type = 2'b11;
            d_ub = 1'b1;
            d_wb = 1'b1;
          end
          4'hC: begin
            d_type = take ? 2'b11 : 2'b00;
            d_ub = 1'b1;
          end
          default: d_ill = 1'b1;
        endcase
      default: d_ill = 1'b1;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dec_valid <= 1'b0;
      opcode <= '0;
      rdest <= '0;
      src_a <= '0;
      src_b <= '0;
      use_a <= 1'b0;
      use_b <= 1'b0;
      imm <= '0;
      instr_type <= 2'b00;
      wb <= 1'b0;
      illegal <= 1'b0;
    end else if (accept) begin
      dec_valid <= 1'b1;
      opcode <= {hi, ext};
      rdest <= REG_AW'(instr[11:8]);
      src_a <= REG_AW'(instr[11:8]);
      src_b <= REG_AW'(instr[3:0]);
      use_a <= d_ua;
      use_b <= d_ub;
      imm <= d_imm;
      instr_type <= d_type;
      wb <= d_wb;
      illegal <= d_ill;
    end else if (dec_ready) dec_valid <= 1'b0;
`ifdef DECODE_SCOREBOARD_EN
  localparam int CW = $clog2(MAX_LD + 1);
  logic [CW-1:0] ld_cnt;
  logic inc, dec;
  logic [NUM_REGS-1:0] set_m, clr_m;
  assign inc = accept & is_load;
  assign dec = ld_done & (ld_cnt != '0);
  assign set_m = inc ? NUM_REGS'(1) << instr[11:8] : '0;
  assign clr_m = dec ? NUM_REGS'(1) << ld_reg : '0;
  // ld_busy is registered, so a same-cycle ld_done only releases the stall next cycle
  assign hazard = (d_ua & ld_busy[instr[11:8]]) | (d_ub & ld_busy[instr[3:0]])
                | (d_wb & ld_busy[instr[11:8]]) | (is_load & ld_cnt == CW'(MAX_LD));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ld_busy <= '0;
      ld_cnt <= '0;
    end else begin
      ld_busy <= (ld_busy & ~clr_m) | set_m;
      ld_cnt <= ld_cnt + CW'(inc) - CW'(dec);
    end
`else
  logic unused_sb;
  assign unused_sb = ^{ld_done, ld_reg, is_load};
  assign hazard = 1'b0;
  assign ld_busy = '0;
`endif
endmodule
